data_cache_ctrl: RTL



---
 rtl/data_cache_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/data_cache_ctrl.sv
// data_cache_ctrl: direct-mapped, write-back, write-allocate data cache between an 8-bit
// CPU load/store port and a 32-bit-block data memory.
//
// Ports:
//   CLK, RESET            clock and synchronous active-high reset
//   READ, WRITE           CPU load / store request (both high is a store)
//   ADDRESS               CPU byte address {tag, index, offset}
//   WRITEDATA, READDATA   CPU store byte / load byte
//   BUSYWAIT              stall to CPU
//   MEM_READ, MEM_WRITE   block fetch / write-back strobes to memory
//   MEM_ADDRESS           block address {tag, index}
//   MEM_WRITEDATA         block being written back (byte0 in [7:0])
//   MEM_READDATA          block returned by memory (byte0 in [7:0])
//   MEM_BUSYWAIT          memory busy
module data_cache_ctrl #(
    parameter int unsigned INDEX_BITS = 3
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        READ,
    input  logic        WRITE,
    input  logic [7:0]  ADDRESS,
    input  logic [7:0]  WRITEDATA,
    output logic [7:0]  READDATA,
    output logic        BUSYWAIT,
    output logic        MEM_READ,
    output logic        MEM_WRITE,
    output logic [5:0]  MEM_ADDRESS,
    output logic [31:0] MEM_WRITEDATA,
    input  logic [31:0] MEM_READDATA,
    input  logic        MEM_BUSYWAIT
);

    localparam int unsigned NumLines = 1 << INDEX_BITS;
    localparam int unsigned TagBits  = 8 - INDEX_BITS - 2;

    typedef enum logic [1:0] {
        StIdle,
        StWriteback,
        StFetch
    } state_e;

    state_e state_q, state_d;

    // Data and tag arrays are deliberately not reset; valid/dirty gate their use.
    logic [31:0]         data_q  [NumLines];
    logic [TagBits-1:0]  tag_q   [NumLines];
    logic [NumLines-1:0] valid_q;
    logic [NumLines-1:0] dirty_q;

    logic [INDEX_BITS-1:0] index;
    logic [TagBits-1:0]    tag;
    logic [1:0]            offset;
    logic [31:0]           line;
    logic                  access;
    logic                  hit;

    assign index  = ADDRESS[INDEX_BITS+1:2];
    assign tag    = ADDRESS[7:INDEX_BITS+2];
    assign offset = ADDRESS[1:0];
    assign line   = data_q[index];
    assign access = READ | WRITE;
    assign hit    = access & valid_q[index] & (tag_q[index] == tag);

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (access && !hit) begin
                    state_d = (valid_q[index] && dirty_q[index]) ? StWriteback : StFetch;
                end
            end
            StWriteback: begin
                if (!MEM_BUSYWAIT) state_d = StFetch;
            end
            StFetch: begin
                if (!MEM_BUSYWAIT) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        BUSYWAIT      = (access & ~hit) | (state_q != StIdle);
        READDATA      = '0;
        MEM_READ      = 1'b0;
        MEM_WRITE     = 1'b0;
        MEM_ADDRESS   = '0;
        MEM_WRITEDATA = '0;
        // A simultaneous READ and WRITE is a store, so no load data is returned.
        if (READ && !WRITE && hit) begin
            READDATA = line[{offset, 3'b000} +: 8];
        end
        unique case (state_q)
            StWriteback: begin
                MEM_WRITE     = 1'b1;
                MEM_ADDRESS   = {tag_q[index], index};
                MEM_WRITEDATA = line;
            end
            StFetch: begin
                MEM_READ    = 1'b1;
                MEM_ADDRESS = ADDRESS[7:2];
            end
            default: ;
        endcase
    end

    // Line storage: store hits, write-back completion and block fill
    always_ff @(posedge CLK) begin
        if (RESET) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            if (state_q == StIdle && WRITE && hit) begin
                data_q[index][{offset, 3'b000} +: 8] <= WRITEDATA;
                dirty_q[index]                       <= 1'b1;
            end
            if (state_q == StWriteback && !MEM_BUSYWAIT) begin
                dirty_q[index] <= 1'b0;
            end
            // After the fill the held request hits on the next cycle and completes normally.
            if (state_q == StFetch && !MEM_BUSYWAIT) begin
                data_q[index]  <= MEM_READDATA;
                tag_q[index]   <= tag;
                valid_q[index] <= 1'b1;
                dirty_q[index] <= 1'b0;
            end
        end
    end

endmodule
